// File: rtl/logic_op_arbiter.sv
// Two-requester round-robin arbiter feeding one registered bitwise-logic unit.
// Optional enable port: define LOGIC_ARB_ENABLE_PORT_EN to add it.
module logic_op_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef LOGIC_ARB_ENABLE_PORT_EN
    input  logic             enable,
`endif
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             arb_en;
    logic             grant0;
    logic             grant1;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

`ifdef LOGIC_ARB_ENABLE_PORT_EN
    assign arb_en = enable;
`else
    assign arb_en = 1'b1;
`endif

    assign rsp_valid  = (state == HOLD);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Grant selection and next state; ties go to the requester not granted last.
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!rst && arb_en) begin
                    grant0 = req0_valid && (!req1_valid || last_grant);
                    grant1 = req1_valid && (!req0_valid || !last_grant);
                end
                if (grant0 || grant1)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand mux and purely bitwise operation of the granted requester.
    always_comb begin
        sel_op = grant1 ? req1_op : req0_op;
        sel_a  = grant1 ? req1_a  : req0_a;
        sel_b  = grant1 ? req1_b  : req0_b;
        unique case (sel_op)
            2'b00:   result = sel_a & sel_b;
            2'b01:   result = sel_a | sel_b;
            2'b10:   result = sel_a ^ sel_b;
            default: result = ~(sel_a | sel_b);
        endcase
    end

    // State, captured result and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rsp_data   <= '0;
            rsp_id     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (grant0 || grant1) begin
                rsp_data   <= result;
                rsp_id     <= grant1;
                last_grant <= grant1;
            end
        end
    end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed testbench for logic_op_arbiter.
// Enable-port scenario runs only when LOGIC_ARB_ENABLE_PORT_EN is defined.
module tb_logic_op_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_data;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logic_op_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef LOGIC_ARB_ENABLE_PORT_EN
        .enable     (enable),
`endif
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_op    = 2'b00;
        req1_op    = 2'b00;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        rsp_ready  = 1'b1;
        enable     = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        rst = 1'b1;
        step();
        step();
        #1;
        n_vec++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
        end
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp got v=%b d=%h id=%b want 0/0/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        rst = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_op    = 2'b01;
        req0_a     = 32'h0000129F;
        req0_b     = 32'h00000BD2;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL single_ready got %b%b want 10", req0_ready, req1_ready);
        end
        step();
        req0_valid = 1'b0;
        #1;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h00001BDF || rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL single_rsp got v=%b d=%h id=%b want 1/00001bdf/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        step();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_release got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic         exp_hold;
        logic         exp_win;
        logic [W-1:0] exp_d;
        idle_inputs();
        do_reset();
        req0_valid = 1'b1;
        req0_op    = 2'b00;
        req0_a     = 32'hF0F01234;
        req0_b     = 32'h0FF0FF00;
        req1_valid = 1'b1;
        req1_op    = 2'b10;
        req1_a     = 32'h12345678;
        req1_b     = 32'hFFFF0000;
        exp_hold = 1'b0;
        exp_win  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (!exp_hold) begin
                n_vec++;
                if (req0_ready !== !exp_win || req1_ready !== exp_win) begin
                    n_err++;
                    $display("FAIL b2b_grant cyc %0d got %b%b want winner %0d",
                             i, req0_ready, req1_ready, exp_win);
                end
            end else begin
                exp_d = exp_win ? 32'hEDCB5678 : 32'h00F01200;
                n_vec++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
                    rsp_valid !== 1'b1 || rsp_id !== exp_win ||
                    rsp_data !== exp_d) begin
                    n_err++;
                    $display("FAIL b2b_rsp cyc %0d got r=%b%b v=%b id=%b d=%h want 00/1/%b/%h",
                             i, req0_ready, req1_ready, rsp_valid, rsp_id,
                             rsp_data, exp_win, exp_d);
                end
                exp_win = !exp_win;
            end
            exp_hold = !exp_hold;
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_hold_stall();
        idle_inputs();
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_op    = 2'b10;
        req0_a     = 32'hFFFFFFFF;
        req0_b     = 32'hA8492525;
        step();
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h57B6DADA ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                n_err++;
                $display("FAIL stall cyc %0d got v=%b d=%h r=%b%b want 1/57b6dada/00",
                         i, rsp_valid, rsp_data, req0_ready, req1_ready);
            end
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready  = 1'b1;
        step();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_release got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_ops();
        logic [1:0]   t_op [4] = '{2'b11, 2'b00, 2'b11, 2'b01};
        logic [W-1:0] t_a  [4] = '{32'h00000000, 32'hFFFFFFFF,
                                   32'h0F0F0000, 32'hA5A50000};
        logic [W-1:0] t_b  [4] = '{32'h00000000, 32'h00000000,
                                   32'h00F0F00F, 32'h0000C3C3};
        logic [W-1:0] t_e  [4] = '{32'hFFFFFFFF, 32'h00000000,
                                   32'hF0000FF0, 32'hA5A5C3C3};
        idle_inputs();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req1_valid = 1'b1;
            req1_op    = t_op[i];
            req1_a     = t_a[i];
            req1_b     = t_b[i];
            step();
            req1_valid = 1'b0;
            #1;
            n_vec++;
            if (rsp_valid !== 1'b1 || rsp_data !== t_e[i] || rsp_id !== 1'b1) begin
                n_err++;
                $display("FAIL ops[%0d] got v=%b d=%h id=%b want 1/%h/1",
                         i, rsp_valid, rsp_data, rsp_id, t_e[i]);
            end
            step();
        end
    endtask

    task automatic test_reset_in_hold();
        idle_inputs();
        do_reset();
        rsp_ready  = 1'b0;
        req1_valid = 1'b1;
        req1_op    = 2'b01;
        req1_a     = 32'h0000F000;
        req1_b     = 32'h0000000F;
        step();
        req1_valid = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000F00F) begin
            n_err++;
            $display("FAIL rsthold_pre got v=%b d=%h want 1/0000f00f",
                     rsp_valid, rsp_data);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            n_err++;
            $display("FAIL rsthold_clear got v=%b d=%h id=%b want 0/0/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_vec++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rsthold_tie got %b%b want 10", req0_ready, req1_ready);
        end
        rsp_ready = 1'b1;
        step();
        idle_inputs();
        step();
    endtask

`ifdef LOGIC_ARB_ENABLE_PORT_EN
    task automatic test_enable();
        idle_inputs();
        do_reset();
        rsp_ready  = 1'b0;
        req0_valid = 1'b1;
        req0_op    = 2'b01;
        req0_a     = 32'h00000011;
        req0_b     = 32'h00000100;
        step();
        req0_valid = 1'b0;
        enable     = 1'b0;
        rsp_ready  = 1'b1;
        step();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL en_hold_done got %b want 0", rsp_valid);
        end
        req1_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_vec++;
            if (req1_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL en_block cyc %0d got r1=%b v=%b want 0/0",
                         i, req1_ready, rsp_valid);
            end
            step();
        end
        enable = 1'b1;
        #1;
        n_vec++;
        if (req1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL en_resume got %b want 1", req1_ready);
        end
        step();
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_stall();
        test_ops();
        test_reset_in_hold();
`ifdef LOGIC_ARB_ENABLE_PORT_EN
        test_enable();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port: req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 Port: req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 Port: req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meaning as REQ-004 to REQ-007, for requester 1.
REQ-009 Port: rsp_valid  output  1  result held on rsp_data.
REQ-010 Port: rsp_ready  input  1  consumer accepts result.
REQ-011 Port: rsp_data  output  WIDTH  registered bitwise result.
REQ-012 Port: rsp_id  output  1  index of the requester that owns rsp_data.
REQ-013 Port: enable  input  1  arbitration enable; present only under LOGIC_ARB_ENABLE_PORT_EN.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-015 In IDLE with at least one valid request and arbitration enabled, the block SHALL grant exactly one requester, asserting that requester's reqN_ready combinationally in the same cycle.
REQ-016 A single valid requester SHALL always be granted; with both valid, the grant SHALL go to the requester not granted most recently (round-robin via a last_grant register).
REQ-017 On grant, the block SHALL register rsp_data = op(a,b) of the granted requester, set rsp_id to its index, set rsp_valid=1 and move to HOLD at the next edge (latency 1 cycle from handshake to rsp_valid).
REQ-018 reqN_ready SHALL be 0 in HOLD and 0 for any requester with reqN_valid=0.
REQ-019 In HOLD, rsp_data, rsp_id and rsp_valid SHALL remain stable until rsp_ready=1 is sampled; the block SHALL then return to IDLE with rsp_valid=0 next cycle.
REQ-020 A grant SHALL NOT occur in the same cycle as the response handshake; the peak rate is one operation per 2 cycles.
REQ-021 NOR SHALL be the bitwise inverse of OR over all WIDTH bits; all ops SHALL be purely bitwise with no carry.
REQ-022 last_grant SHALL update only on a grant.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL force state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=1 (requester 0 wins the first tie); req0_ready and req1_ready SHALL be 0 while rst=1.
REQ-024 A rst asserted during HOLD SHALL discard the held result, with no rsp handshake.

Configuration
REQ-025 Macro LOGIC_ARB_ENABLE_PORT_EN defined: the enable port SHALL exist; with enable=0, no new grants SHALL occur (both ready=0), and any result already in HOLD SHALL still complete its handshake normally.
REQ-026 Macro LOGIC_ARB_ENABLE_PORT_EN undefined: the enable port SHALL be absent and arbitration SHALL behave as permanently enabled.

Verification
REQ-027 After reset, assert req0 alone with OR, a=0x0000129F, b=0x00000BD2 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_data=0x00001BDF, rsp_id=0.
REQ-028 Assert both valid from reset, both held, rsp_ready=1 -> grants alternate 0,1,0,1 on every other cycle; rsp_id follows the grants.
REQ-029 With rsp_ready=0 for 5 cycles in HOLD (XOR, a=0xFFFFFFFF, b=0xA8492525) -> rsp_data stays 0x57B6DADA, both ready=0; when rsp_ready=1, rsp_valid=0 next cycle.
REQ-030 Assert NOR with a=0x00000000, b=0x00000000 -> rsp_data=0xFFFFFFFF; AND with a=0xFFFFFFFF, b=0x00000000 -> rsp_data=0x00000000.
REQ-031 Assert rst in HOLD -> next cycle rsp_valid=0, rsp_data=0; a subsequent tie is granted to requester 0.
REQ-032 Under LOGIC_ARB_ENABLE_PORT_EN, enable=0 while req1 is valid -> req1_ready=0 indefinitely; a result already in HOLD still handshakes; enable=1 -> grant next IDLE cycle.
